// File: rtl/dmem_pkg.sv
// Shared types and sizes for the data-memory arbiter slice.
package dmem_pkg;

   localparam int DMEM_DW = 16;
   localparam int DMEM_AW = 5;
   localparam int DMEM_CW = 4;   // starvation counter width

   // Which requester, if any, owns the read data returning this cycle
   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_CPU  = 2'd1,
      OWN_DMA  = 2'd2
   } owner_t;

   // Which requester wins when both ask in the same cycle
   typedef enum logic {
      CPU_PRI = 1'b0,
      DMA_PRI = 1'b1
   } pri_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the memory.
//
// Handshake: a requester raises *_req together with *_we/*_addr/*_wdata and
// keeps all four stable until it sees *_gnt high in the same cycle; the
// access is consumed in that grant cycle. A granted read returns *_rvalid
// exactly one cycle later with *_rdata. mem_dout is valid the cycle after
// mem_addr was presented.
interface dmem_arbiter_if
   import dmem_pkg::*;
   ();

   logic               cpu_req;
   logic               cpu_we;
   logic [DMEM_AW-1:0] cpu_addr;
   logic [DMEM_DW-1:0] cpu_wdata;
   logic               cpu_gnt;
   logic               cpu_rvalid;
   logic [DMEM_DW-1:0] cpu_rdata;

   logic               dma_req;
   logic               dma_we;
   logic [DMEM_AW-1:0] dma_addr;
   logic [DMEM_DW-1:0] dma_wdata;
   logic               dma_gnt;
   logic               dma_rvalid;
   logic [DMEM_DW-1:0] dma_rdata;

   logic               mem_we;
   logic [DMEM_AW-1:0] mem_addr;
   logic [DMEM_DW-1:0] mem_di;
   logic [DMEM_DW-1:0] mem_dout;

   // Arbiter side
   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
      output cpu_gnt, cpu_rvalid, cpu_rdata,
      input  dma_req, dma_we, dma_addr, dma_wdata,
      output dma_gnt, dma_rvalid, dma_rdata,
      output mem_we, mem_addr, mem_di,
      input  mem_dout
   );

   // Requester / memory side
   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata,
      input  cpu_gnt, cpu_rvalid, cpu_rdata,
      output dma_req, dma_we, dma_addr, dma_wdata,
      input  dma_gnt, dma_rvalid, dma_rdata,
      input  mem_we, mem_addr, mem_di,
      output mem_dout
   );

endinterface

// File: rtl/dmem_starve_cnt.sv
// DMA starvation counter: counts consecutive denied DMA cycles and flips
// priority to the DMA port once the count reaches MAX_WAIT.
module dmem_starve_cnt
   import dmem_pkg::*;
#(
   parameter int MAX_WAIT = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               dma_req_i,
   input  logic               dma_gnt_i,
   output logic [DMEM_CW-1:0] wait_cnt_o,
   output pri_t               pri_o
);

   localparam logic [DMEM_CW-1:0] MAX_WAIT_C = DMEM_CW'(MAX_WAIT);
   localparam logic [DMEM_CW-1:0] CNT_SAT    = '1;

   logic [DMEM_CW-1:0] wait_cnt_q, wait_cnt_d;
   pri_t               pri_q, pri_d;

   // Next count and priority; a DMA grant clears both back to CPU default
   always_comb begin
      wait_cnt_d = wait_cnt_q;
      pri_d      = pri_q;
      if (dma_gnt_i) begin
         wait_cnt_d = '0;
      end else if (dma_req_i && (wait_cnt_q != CNT_SAT)) begin
         wait_cnt_d = wait_cnt_q + 1'b1;
      end
      if (dma_gnt_i) begin
         pri_d = CPU_PRI;
      end else if (wait_cnt_d >= MAX_WAIT_C) begin
         pri_d = DMA_PRI;
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wait_cnt_q <= '0;
         pri_q      <= CPU_PRI;
      end else begin
         wait_cnt_q <= wait_cnt_d;
         pri_q      <= pri_d;
      end
   end

   assign wait_cnt_o = wait_cnt_q;
   assign pri_o      = pri_q;

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter (CPU, DMA) for a single-port synchronous data memory.
// CPU wins by default; the starvation counter hands priority to DMA after
// MAX_WAIT denied cycles. Read data is steered back by a one-cycle owner tag.
module dmem_arbiter
   import dmem_pkg::*;
#(
   parameter int MAX_WAIT = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   dmem_arbiter_if.slave      bus,
   output logic [DMEM_CW-1:0] dbg_wait_cnt_o,
   output pri_t               dbg_pri_o,
   output owner_t             dbg_rd_owner_o
);

   logic               cpu_gnt;
   logic               dma_gnt;
   pri_t               pri;
   logic [DMEM_CW-1:0] wait_cnt;
   owner_t             rd_owner_q, rd_owner_d;

   dmem_starve_cnt #(
      .MAX_WAIT (MAX_WAIT)
   ) u_starve_cnt (
      .clk        (clk),
      .rst_n      (rst_n),
      .dma_req_i  (bus.dma_req),
      .dma_gnt_i  (dma_gnt),
      .wait_cnt_o (wait_cnt),
      .pri_o      (pri)
   );

   // Grant selection; everything is held off while reset is asserted
   always_comb begin
      cpu_gnt = 1'b0;
      dma_gnt = 1'b0;
      if (rst_n) begin
         if (pri == DMA_PRI) begin
            dma_gnt = bus.dma_req;
            cpu_gnt = bus.cpu_req & ~bus.dma_req;
         end else begin
            cpu_gnt = bus.cpu_req;
            dma_gnt = bus.dma_req & ~bus.cpu_req;
         end
      end
   end

   // Memory port mux: CPU inputs are the idle default
   always_comb begin
      bus.mem_addr = bus.cpu_addr;
      bus.mem_di   = bus.cpu_wdata;
      bus.mem_we   = bus.cpu_we & cpu_gnt;
      if (dma_gnt) begin
         bus.mem_addr = bus.dma_addr;
         bus.mem_di   = bus.dma_wdata;
         bus.mem_we   = bus.dma_we;
      end
   end

   // Tag the owner of a read granted this cycle
   always_comb begin
      rd_owner_d = OWN_NONE;
      if (cpu_gnt && !bus.cpu_we) begin
         rd_owner_d = OWN_CPU;
      end else if (dma_gnt && !bus.dma_we) begin
         rd_owner_d = OWN_DMA;
      end
   end

   // Owner register; reset drops any read still in flight
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_owner_q <= OWN_NONE;
      end else begin
         rd_owner_q <= rd_owner_d;
      end
   end

   assign bus.cpu_gnt    = cpu_gnt;
   assign bus.dma_gnt    = dma_gnt;
   assign bus.cpu_rvalid = (rd_owner_q == OWN_CPU);
   assign bus.dma_rvalid = (rd_owner_q == OWN_DMA);
   assign bus.cpu_rdata  = bus.mem_dout;
   assign bus.dma_rdata  = bus.mem_dout;

   assign dbg_wait_cnt_o = wait_cnt;
   assign dbg_pri_o      = pri;
   assign dbg_rd_owner_o = rd_owner_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: directed vector table, hand-written corner
// sequences and a randomized phase, all checked against a reference model.
module tb_dmem_arbiter;
   import dmem_pkg::*;

   localparam int MAX_WAIT = 4;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   dmem_arbiter_if bus();

   logic [3:0] dbg_wait_cnt;
   pri_t       dbg_pri;
   owner_t     dbg_rd_owner;

   dmem_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .bus            (bus),
      .dbg_wait_cnt_o (dbg_wait_cnt),
      .dbg_pri_o      (dbg_pri),
      .dbg_rd_owner_o (dbg_rd_owner)
   );

   // Memory: synchronous write, synchronous read-before-write
   logic [15:0] mem_arr [32];
   initial begin
      for (int i = 0; i < 32; i++) mem_arr[i] = 16'h0000;
   end
   always @(posedge clk) begin
      if (bus.mem_we) mem_arr[bus.mem_addr] <= bus.mem_di;
      bus.mem_dout <= mem_arr[bus.mem_addr];
   end

   // ---------------- scoreboard / reference model ----------------
   int n_checks = 0;
   int n_errors = 0;

   logic [15:0] exp_q[$];         // read data owed to a requester
   logic [15:0] mem_m [32];       // model of memory contents
   int          denied_m = 0;     // DMA cycles denied since its last grant (sat 15)
   int          pend_m   = 0;     // 0 none, 1 CPU, 2 DMA read returning
   logic        m_cgnt, m_dgnt;   // model grants of the current cycle

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Compare the DUT's current cycle against the model, then advance the model
   task automatic model_cycle();
      logic dma_first;
      logic [15:0] rd;
      dma_first = (denied_m >= MAX_WAIT);
      m_cgnt = 1'b0;
      m_dgnt = 1'b0;
      if (rst_n) begin
         if (dma_first) begin
            m_dgnt = bus.dma_req;
            m_cgnt = bus.cpu_req && !bus.dma_req;
         end else begin
            m_cgnt = bus.cpu_req;
            m_dgnt = bus.dma_req && !bus.cpu_req;
         end
      end
      chk("gnt", {bus.cpu_gnt, bus.dma_gnt}, {m_cgnt, m_dgnt});
      chk("mem_we", bus.mem_we, (m_cgnt && bus.cpu_we) || (m_dgnt && bus.dma_we));
      chk("mem_addr", bus.mem_addr, m_dgnt ? bus.dma_addr : bus.cpu_addr);
      chk("mem_di", bus.mem_di, m_dgnt ? bus.dma_wdata : bus.cpu_wdata);
      chk("rvalid", {bus.cpu_rvalid, bus.dma_rvalid}, {pend_m == 1, pend_m == 2});
      if (pend_m != 0 && exp_q.size() > 0) begin
         rd = exp_q.pop_front();
         chk(pend_m == 1 ? "cpu_rdata" : "dma_rdata",
             pend_m == 1 ? bus.cpu_rdata : bus.dma_rdata, rd);
      end
      chk("wait_cnt", dbg_wait_cnt, denied_m);
      chk("pri", dbg_pri, dma_first ? DMA_PRI : CPU_PRI);

      // advance to the next cycle
      if (!rst_n) begin
         denied_m = 0;
         pend_m   = 0;
         exp_q.delete();
      end else begin
         if (m_dgnt) denied_m = 0;
         else if (bus.dma_req && denied_m < 15) denied_m++;
         pend_m = 0;
         if (m_cgnt) begin
            if (bus.cpu_we) mem_m[bus.cpu_addr] = bus.cpu_wdata;
            else begin pend_m = 1; exp_q.push_back(mem_m[bus.cpu_addr]); end
         end else if (m_dgnt) begin
            if (bus.dma_we) mem_m[bus.dma_addr] = bus.dma_wdata;
            else begin pend_m = 2; exp_q.push_back(mem_m[bus.dma_addr]); end
         end
      end
   endtask

   // ---------------- driver ----------------
   task automatic apply(input logic rst, input logic creq, input logic cwe,
                        input logic [4:0] caddr, input logic [15:0] cwd,
                        input logic dreq, input logic dwe,
                        input logic [4:0] daddr, input logic [15:0] dwd);
      @(negedge clk);
      rst_n         = rst;
      bus.cpu_req   = creq;
      bus.cpu_we    = cwe;
      bus.cpu_addr  = caddr;
      bus.cpu_wdata = cwd;
      bus.dma_req   = dreq;
      bus.dma_we    = dwe;
      bus.dma_addr  = daddr;
      bus.dma_wdata = dwd;
      #1;
      model_cycle();
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic        rst;
      logic        creq, cwe;
      logic [4:0]  caddr;
      logic [15:0] cwd;
      logic        dreq, dwe;
      logic [4:0]  daddr;
      logic [15:0] dwd;
      logic [1:0]  egnt;   // {cpu, dma}
      logic [1:0]  erv;    // {cpu, dma}
      logic [15:0] erd;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(input logic rst, input logic creq, input logic cwe,
                               input logic [4:0] caddr, input logic [15:0] cwd,
                               input logic dreq, input logic dwe,
                               input logic [4:0] daddr, input logic [15:0] dwd,
                               input logic [1:0] egnt, input logic [1:0] erv,
                               input logic [15:0] erd);
      vec_t v;
      v.rst = rst; v.creq = creq; v.cwe = cwe; v.caddr = caddr; v.cwd = cwd;
      v.dreq = dreq; v.dwe = dwe; v.daddr = daddr; v.dwd = dwd;
      v.egnt = egnt; v.erv = erv; v.erd = erd;
      vecs.push_back(v);
   endfunction

   logic        r_rst, r_creq, r_cwe, r_dreq, r_dwe;
   logic [4:0]  r_caddr, r_daddr;
   logic [15:0] r_cwd, r_dwd;
   logic        c_hold, d_hold;

   initial begin
      for (int i = 0; i < 32; i++) mem_m[i] = 16'h0000;
      rst_n = 1'b0;
      bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
      bus.dma_req = 1'b0; bus.dma_we = 1'b0; bus.dma_addr = '0; bus.dma_wdata = '0;

      // reset with both requesting, then release
      for (int i = 0; i < 3; i++)
         add(0, 1, 0, 5'd0, 16'h0, 1, 0, 5'd0, 16'h0, 2'b00, 2'b00, 16'h0);
      add(1, 1, 0, 5'd0, 16'h0,    1, 0, 5'd0,  16'h0,    2'b10, 2'b00, 16'h0);
      // CPU write/read of address 5
      add(1, 1, 1, 5'd5, 16'hBEEF, 0, 0, 5'd0,  16'h0,    2'b10, 2'b10, 16'h0000);
      add(1, 1, 0, 5'd5, 16'h0,    0, 0, 5'd0,  16'h0,    2'b10, 2'b00, 16'h0);
      add(1, 0, 0, 5'd0, 16'h0,    0, 0, 5'd0,  16'h0,    2'b00, 2'b10, 16'hBEEF);
      // DMA-only read of the top address
      add(1, 0, 0, 5'd0, 16'h0,    1, 0, 5'd31, 16'h0,    2'b01, 2'b00, 16'h0);
      add(1, 1, 1, 5'd1, 16'h1111, 0, 0, 5'd0,  16'h0,    2'b10, 2'b01, 16'h0000);
      add(1, 0, 0, 5'd0, 16'h0,    1, 1, 5'd2,  16'h2222, 2'b01, 2'b00, 16'h0);
      // interleaved CPU then DMA reads
      add(1, 1, 0, 5'd1, 16'h0,    0, 0, 5'd0,  16'h0,    2'b10, 2'b00, 16'h0);
      add(1, 0, 0, 5'd0, 16'h0,    1, 0, 5'd2,  16'h0,    2'b01, 2'b10, 16'h1111);
      add(1, 0, 0, 5'd0, 16'h0,    0, 0, 5'd0,  16'h0,    2'b00, 2'b01, 16'h2222);
      // read then write same address returns old data
      add(1, 1, 0, 5'd5, 16'h0,    0, 0, 5'd0,  16'h0,    2'b10, 2'b00, 16'h0);
      add(1, 1, 1, 5'd5, 16'h1234, 0, 0, 5'd0,  16'h0,    2'b10, 2'b10, 16'hBEEF);
      add(1, 1, 0, 5'd5, 16'h0,    0, 0, 5'd0,  16'h0,    2'b10, 2'b00, 16'h0);
      add(1, 0, 0, 5'd0, 16'h0,    0, 0, 5'd0,  16'h0,    2'b00, 2'b10, 16'h1234);
      // continuous contention: period of 5 with DMA on every 5th cycle
      for (int i = 0; i < 10; i++)
         add(1, 1, 0, 5'd3, 16'h0, 1, 0, 5'd4, 16'h0,
             (i == 4 || i == 9) ? 2'b01 : 2'b10,
             (i == 0) ? 2'b00 : ((i == 5) ? 2'b01 : 2'b10), 16'h0);
      add(1, 0, 0, 5'd0, 16'h0,    0, 0, 5'd0,  16'h0,    2'b00, 2'b01, 16'h0);

      foreach (vecs[k]) begin
         apply(vecs[k].rst, vecs[k].creq, vecs[k].cwe, vecs[k].caddr, vecs[k].cwd,
               vecs[k].dreq, vecs[k].dwe, vecs[k].daddr, vecs[k].dwd);
         chk($sformatf("vec%0d_gnt", k), {bus.cpu_gnt, bus.dma_gnt}, vecs[k].egnt);
         chk($sformatf("vec%0d_rv", k), {bus.cpu_rvalid, bus.dma_rvalid}, vecs[k].erv);
         if (vecs[k].erv[1]) chk($sformatf("vec%0d_crd", k), bus.cpu_rdata, vecs[k].erd);
         if (vecs[k].erv[0]) chk($sformatf("vec%0d_drd", k), bus.dma_rdata, vecs[k].erd);
      end

      // DMA priority held while DMA drops its request
      for (int i = 0; i < MAX_WAIT; i++)
         apply(1, 1, 0, 5'd6, 16'h0, 1, 0, 5'd7, 16'h0);
      apply(1, 1, 0, 5'd6, 16'h0, 0, 0, 5'd7, 16'h0);
      chk("dropped_cpu_gnt", bus.cpu_gnt, 1'b1);
      chk("dropped_pri", dbg_pri, DMA_PRI);
      apply(1, 1, 0, 5'd6, 16'h0, 1, 0, 5'd7, 16'h0);
      chk("dma_pri_gnt", {bus.cpu_gnt, bus.dma_gnt}, 2'b01);
      chk("dma_pri_still", dbg_pri, DMA_PRI);
      apply(1, 0, 0, 5'd0, 16'h0, 0, 0, 5'd0, 16'h0);
      chk("pri_back_cpu", dbg_pri, CPU_PRI);
      chk("wait_clear", dbg_wait_cnt, 4'd0);

      // reset in the cycle after a granted CPU read
      apply(1, 1, 0, 5'd6, 16'h0, 1, 0, 5'd7, 16'h0);
      apply(1, 1, 0, 5'd1, 16'h0, 1, 0, 5'd7, 16'h0);
      chk("pre_rst_wait", dbg_wait_cnt, 4'd1);
      apply(0, 0, 0, 5'd0, 16'h0, 1, 0, 5'd7, 16'h0);
      chk("in_rst_gnt", {bus.cpu_gnt, bus.dma_gnt, bus.mem_we}, 3'b000);
      apply(1, 0, 0, 5'd0, 16'h0, 0, 0, 5'd0, 16'h0);
      chk("post_rst_rv", bus.cpu_rvalid, 1'b0);
      chk("post_rst_wait", dbg_wait_cnt, 4'd0);

      // randomized traffic obeying the hold-until-granted rule
      c_hold = 1'b0;
      d_hold = 1'b0;
      r_creq = 0; r_cwe = 0; r_caddr = 0; r_cwd = 0;
      r_dreq = 0; r_dwe = 0; r_daddr = 0; r_dwd = 0;
      for (int i = 0; i < 600; i++) begin
         r_rst = ($urandom_range(0, 59) != 0);
         if (!c_hold) begin
            r_creq  = ($urandom_range(0, 3) != 0);
            r_cwe   = 1'($urandom_range(0, 1));
            r_caddr = 5'($urandom_range(0, 31));
            r_cwd   = 16'($urandom);
         end
         if (!d_hold) begin
            r_dreq  = 1'($urandom_range(0, 1));
            r_dwe   = 1'($urandom_range(0, 1));
            r_daddr = 5'($urandom_range(0, 31));
            r_dwd   = 16'($urandom);
         end
         apply(r_rst, r_creq, r_cwe, r_caddr, r_cwd, r_dreq, r_dwe, r_daddr, r_dwd);
         c_hold = r_creq && !m_cgnt;
         d_hold = r_dreq && !m_dgnt;
      end

      // ---------------- final report ----------------
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter for the shared single-port 32x16 data memory (synchronous write, synchronous read).
- Requester 0 is the CPU load/store port; requester 1 is a DMA/debug port.
- Grants at most one access per cycle and routes read data back to the requester that issued the read.
- CPU has default priority; a starvation counter guarantees DMA forward progress.

Parameters:
DW  16  data width
AW  5  memory address width (32 words)
MAX_WAIT  4  consecutive denied DMA cycles before DMA gets priority (range 1..15)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  synchronous active-low reset
cpu_req  in  1  CPU access request
cpu_we  in  1  1=write, 0=read
cpu_addr  in  AW  CPU address
cpu_wdata  in  DW  CPU write data
cpu_gnt  out  1  CPU access accepted this cycle
cpu_rvalid  out  1  CPU read data valid (one cycle after a granted read)
cpu_rdata  out  DW  CPU read data
dma_req  in  1  DMA access request
dma_we  in  1  1=write, 0=read
dma_addr  in  AW  DMA address
dma_wdata  in  DW  DMA write data
dma_gnt  out  1  DMA access accepted this cycle
dma_rvalid  out  1  DMA read data valid
dma_rdata  out  DW  DMA read data
mem_we  out  1  to memory write enable
mem_addr  out  AW  to memory address
mem_di  out  DW  to memory write data
mem_dout  in  DW  from memory read data, valid the cycle after address

Behaviour:
- Reset (rst_n=0 at posedge):
  - wait_cnt=0, pri=CPU_PRI, rd_owner=NONE.
  - cpu_rvalid=dma_rvalid=0.
  - While rst_n=0: cpu_gnt=dma_gnt=0 and mem_we=0, gated combinationally.
- Priority state pri ∈ {CPU_PRI, DMA_PRI}:
  - CPU_PRI: if cpu_req, grant CPU; else if dma_req, grant DMA.
  - DMA_PRI: if dma_req, grant DMA; else if cpu_req, grant CPU.
- Grants:
  - Combinational from req and pri; exactly one or zero asserted.
  - A request is consumed in its grant cycle. A requester that is not granted must hold req/we/addr/wdata stable until granted.
- Memory mux (combinational):
  - mem_addr and mem_di come from the granted requester.
  - mem_we = granted requester's we & its gnt.
  - No grant: mem_we=0, mem_addr/mem_di = CPU inputs.
- Starvation counter wait_cnt (4 bits), updated at posedge:
  - dma_req & !dma_gnt: saturating increment.
  - dma_gnt: clear to 0.
  - Otherwise: hold.
- pri update at posedge:
  - Set DMA_PRI when the next wait_cnt value ≥ MAX_WAIT.
  - Return to CPU_PRI on the cycle after any dma_gnt.
- Read return:
  - rd_owner is registered at posedge: CPU if cpu_gnt & !cpu_we; DMA if dma_gnt & !dma_we; else NONE.
  - cpu_rvalid = (rd_owner==CPU); dma_rvalid = (rd_owner==DMA). Both registered, latency exactly 1 cycle.
  - cpu_rdata = dma_rdata = mem_dout; only meaningful with the matching rvalid.
- Back-to-back: grants may occur on every cycle. A read followed by a write to the same address returns the old data (memory read-before-write).
- Boundaries:
  - Simultaneous requests under CPU_PRI: CPU wins, wait_cnt increments.
  - DMA_PRI with dma_req dropped: CPU is granted and pri stays DMA_PRI until a DMA grant occurs.
  - Reset mid-read: the pending rvalid is suppressed.
  - Address wrap: none; AW bits are passed through unchanged.

Decomposition:
- Shared package dmem_pkg:
  - localparams DMEM_DW=16, DMEM_AW=5.
  - Enum owner_t {OWN_NONE, OWN_CPU, OWN_DMA}.
  - Enum pri_t {CPU_PRI, DMA_PRI}.
- One natural sub-module: dmem_starve_cnt (saturating counter plus threshold compare → pri). Everything else stays flat.

Test Plan:
- Reset: rst_n=0 for 3 cycles with both req=1 → gnt=0, mem_we=0, rvalid=0. Release → CPU granted on the first cycle.
- CPU write then read: write addr 5 data 0xBEEF, then read addr 5 → cpu_rvalid=1 with cpu_rdata=0xBEEF one cycle after the read grant; dma_rvalid stays 0.
- Contention, MAX_WAIT=4: both req held continuously → CPU granted 4 cycles, DMA granted on the 5th, CPU on the 6th; pattern repeats with period 5.
- DMA-only traffic: dma_req reads addr 31 while cpu_req=0 → dma_gnt same cycle, dma_rvalid next cycle, wait_cnt stays 0.
- Interleaved reads: CPU read addr 1 (0x1111) at cycle n, DMA read addr 2 (0x2222) at cycle n+1 → cpu_rvalid at n+1 with 0x1111, dma_rvalid at n+2 with 0x2222.
- Reset mid-op: rst_n=0 in the cycle after a granted CPU read → cpu_rvalid=0 next cycle and wait_cnt=0.
